// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg: shared widths, FSM/grant enums and line-alignment helper for dm_arbiter.
package dm_arb_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned LINE_WORDS = 16;
  localparam int unsigned LINE_W     = LINE_WORDS * WORD_W;
  localparam int unsigned LINE_BYTES = LINE_W / 8;
  localparam int unsigned OFF_W      = $clog2(LINE_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IC_BUSY,
    ST_DC_BUSY,
    ST_IC_DONE,
    ST_DC_DONE
  } state_e;

  typedef enum logic {
    GNT_IC = 1'b0,
    GNT_DC = 1'b1
  } grant_e;

  // Clear the byte-within-line offset so refills always start on a line boundary.
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:OFF_W], OFF_W'(0)};
  endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: cache-side and DM-side signals of the arbiter.
// slave = arbiter view, master = environment (caches + DM model) view.
interface dm_arbiter_if;
  import dm_arb_pkg::*;

  logic              ic_read_i;
  logic [ADDR_W-1:0] ic_address_i;
  logic [LINE_W-1:0] ic_data_o;
  logic              ic_ready_o;

  logic              dc_read_i;
  logic              dc_write_i;
  logic [ADDR_W-1:0] dc_address_i;
  logic [WORD_W-1:0] dc_data_i;
  logic [LINE_W-1:0] dc_data_o;
  logic              dc_ready_o;

  logic              dm_read_o;
  logic              dm_write_o;
  logic [ADDR_W-1:0] dm_address_o;
  logic [WORD_W-1:0] dm_data_o;
  logic [LINE_W-1:0] dm_data_i;
  logic              dm_valid_i;

  modport slave (
    input  ic_read_i, ic_address_i,
    output ic_data_o, ic_ready_o,
    input  dc_read_i, dc_write_i, dc_address_i, dc_data_i,
    output dc_data_o, dc_ready_o,
    output dm_read_o, dm_write_o, dm_address_o, dm_data_o,
    input  dm_data_i, dm_valid_i
  );

  modport master (
    output ic_read_i, ic_address_i,
    input  ic_data_o, ic_ready_o,
    output dc_read_i, dc_write_i, dc_address_i, dc_data_i,
    input  dc_data_o, dc_ready_o,
    input  dm_read_o, dm_write_o, dm_address_o, dm_data_o,
    output dm_data_i, dm_valid_i
  );

endinterface

// File: rtl/dm_arb_pick.sv
// dm_arb_pick: combinational 2-way requester pick.
// DM_ARB_RR_EN defined: ties alternate against last_grant; otherwise dcache wins ties.
module dm_arb_pick
  import dm_arb_pkg::*;
(
  input  logic   ic_req_i,
  input  logic   dc_req_i,
  input  grant_e last_grant_i,
  output grant_e grant_o
);

`ifdef DM_ARB_RR_EN
  // Round-robin: on a tie grant whoever was not served last.
  always_comb begin
    grant_o = GNT_IC;
    if (ic_req_i && dc_req_i) begin
      grant_o = (last_grant_i == GNT_IC) ? GNT_DC : GNT_IC;
    end else if (dc_req_i) begin
      grant_o = GNT_DC;
    end
  end
`else
  // Fixed priority ignores history; icache only wins when dcache is quiet.
  logic unused_pick_inputs;
  assign unused_pick_inputs = ic_req_i ^ (last_grant_i == GNT_DC);

  // Fixed priority: any dcache request wins.
  always_comb begin
    grant_o = GNT_IC;
    if (dc_req_i) begin
      grant_o = GNT_DC;
    end
  end
`endif

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the DM port between icache refills and dcache refills/write-throughs.
// Tie policy set in dm_arb_pick by DM_ARB_RR_EN (undefined = dcache priority).
module dm_arbiter
  import dm_arb_pkg::*;
(
  input logic         clk,
  input logic         rst,
  dm_arbiter_if.slave bus
);

  state_e            state_q;
  grant_e            last_grant_q;
  grant_e            grant_c;
  logic              dc_req_c;
  logic              dm_read_q;
  logic              dm_write_q;
  logic [ADDR_W-1:0] dm_address_q;
  logic [WORD_W-1:0] dm_data_q;
  logic [LINE_W-1:0] ic_data_q;
  logic [LINE_W-1:0] dc_data_q;
  logic              ic_ready_q;
  logic              dc_ready_q;

  assign dc_req_c = bus.dc_read_i | bus.dc_write_i;

  dm_arb_pick u_pick (
    .ic_req_i    (bus.ic_read_i),
    .dc_req_i    (dc_req_c),
    .last_grant_i(last_grant_q),
    .grant_o     (grant_c)
  );

  // Arbitration FSM; dm_write_q doubles as the latched transfer direction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GNT_IC;
      dm_read_q    <= 1'b0;
      dm_write_q   <= 1'b0;
      dm_address_q <= '0;
      dm_data_q    <= '0;
      ic_data_q    <= '0;
      dc_data_q    <= '0;
      ic_ready_q   <= 1'b0;
      dc_ready_q   <= 1'b0;
    end else begin
      ic_ready_q <= 1'b0;
      dc_ready_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.ic_read_i || dc_req_c) begin
            last_grant_q <= grant_c;
            if (grant_c == GNT_DC) begin
              state_q <= ST_DC_BUSY;
              // Read+write together is illegal; the write takes precedence.
              if (bus.dc_write_i) begin
                dm_write_q   <= 1'b1;
                dm_address_q <= bus.dc_address_i;
                dm_data_q    <= bus.dc_data_i;
              end else begin
                dm_read_q    <= 1'b1;
                dm_address_q <= line_align(bus.dc_address_i);
              end
            end else begin
              state_q      <= ST_IC_BUSY;
              dm_read_q    <= 1'b1;
              dm_address_q <= line_align(bus.ic_address_i);
            end
          end
        end
        ST_IC_BUSY: begin
          if (bus.dm_valid_i) begin
            ic_data_q  <= bus.dm_data_i;
            dm_read_q  <= 1'b0;
            ic_ready_q <= 1'b1;
            state_q    <= ST_IC_DONE;
          end
        end
        ST_DC_BUSY: begin
          if (bus.dm_valid_i) begin
            if (!dm_write_q) begin
              dc_data_q <= bus.dm_data_i;
            end
            dm_read_q  <= 1'b0;
            dm_write_q <= 1'b0;
            dc_ready_q <= 1'b1;
            state_q    <= ST_DC_DONE;
          end
        end
        ST_IC_DONE, ST_DC_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.dm_read_o    = dm_read_q;
  assign bus.dm_write_o   = dm_write_q;
  assign bus.dm_address_o = dm_address_q;
  assign bus.dm_data_o    = dm_data_q;
  assign bus.ic_data_o    = ic_data_q;
  assign bus.ic_ready_o   = ic_ready_q;
  assign bus.dc_data_o    = dc_data_q;
  assign bus.dc_ready_o   = dc_ready_q;

endmodule
